// File: rtl/pipeline_wb_pkg.sv
// Shared MEM/WB definitions: write-back source and load-type encodings, pipeline entry layout.
// Imported by the EX, MEM and WB stages so the encodings live in one place.
package pipeline_wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned MTR_W  = 2;
  localparam int unsigned LDT_W  = 3;
  localparam int unsigned OFF_W  = 2;

  typedef enum logic [MTR_W-1:0] {
    MTR_ALU = 2'b00,
    MTR_MEM = 2'b01,
    MTR_PC4 = 2'b10
  } mtr_e;

  typedef enum logic [LDT_W-1:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } ld_e;

  // One MEM/WB pipeline slot; off is the latched address byte offset.
  typedef struct packed {
    logic               valid;
    logic               reg_wr;
    logic [MTR_W-1:0]   mtr;
    logic [LDT_W-1:0]   ld_type;
    logic [RADDR_W-1:0] wr_addr;
    logic [OFF_W-1:0]   off;
    logic [XLEN-1:0]    alu;
    logic [XLEN-1:0]    rdata;
    logic [XLEN-1:0]    pc4;
  } mem_wb_t;

  function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
    return sgn ? {{(XLEN-8){b[7]}}, b} : {{(XLEN-8){1'b0}}, b};
  endfunction

  function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
    return sgn ? {{(XLEN-16){h[15]}}, h} : {{(XLEN-16){1'b0}}, h};
  endfunction

endpackage

// File: rtl/pipeline_wb_if.sv
// MEM -> WB bus: MEM-stage results in, write-back data, forwarding and retire count out.
interface pipeline_wb_if #(
  parameter int unsigned CNT_W = 32
);
  import pipeline_wb_pkg::*;

  logic [XLEN-1:0]    Mem_outA;
  logic [XLEN-1:0]    Mem_outB;
  logic [XLEN-1:0]    Mem_PC4;
  logic [RADDR_W-1:0] Mem_WrAddr;
  logic               Mem_RegWr;
  logic [MTR_W-1:0]   Mem_MemtoReg;
  logic [LDT_W-1:0]   Mem_LdType;
  logic               Mem_Valid;
  logic               Mem_MemWr;
  logic [RADDR_W-1:0] Mem_Rt;

  logic [XLEN-1:0]    WB_dataB;
  logic [RADDR_W-1:0] WB_WrAddr;
  logic               WB_RegWr;
  logic               Forwardsw;
  logic [CNT_W-1:0]   WB_retired;

  modport master (
    output Mem_outA, Mem_outB, Mem_PC4, Mem_WrAddr, Mem_RegWr, Mem_MemtoReg,
           Mem_LdType, Mem_Valid, Mem_MemWr, Mem_Rt,
    input  WB_dataB, WB_WrAddr, WB_RegWr, Forwardsw, WB_retired
  );

  modport slave (
    input  Mem_outA, Mem_outB, Mem_PC4, Mem_WrAddr, Mem_RegWr, Mem_MemtoReg,
           Mem_LdType, Mem_Valid, Mem_MemWr, Mem_Rt,
    output WB_dataB, WB_WrAddr, WB_RegWr, Forwardsw, WB_retired
  );

endinterface

// File: rtl/pipeline_wb_load_extend.sv
// Little-endian load extraction: picks byte/halfword by offset and sign/zero-extends.
// Purely combinational; halfword offset bit 0 is ignored (no alignment trap).
module pipeline_wb_load_extend
  import pipeline_wb_pkg::*;
(
  input  logic [XLEN-1:0]  data,
  input  logic [OFF_W-1:0] off,
  input  logic [LDT_W-1:0] ld_type,
  output logic [XLEN-1:0]  result_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(data >> {off, 3'b000});
    half_sel = off[1] ? data[31:16] : data[15:0];
    result_c = data;
    case (ld_type)
      LD_B:    result_c = ext8(byte_sel, 1'b1);
      LD_BU:   result_c = ext8(byte_sel, 1'b0);
      LD_H:    result_c = ext16(half_sel, 1'b1);
      LD_HU:   result_c = ext16(half_sel, 1'b0);
      default: result_c = data;
    endcase
  end

endmodule

// File: rtl/pipeline_wb.sv
// MEM/WB pipeline register and write-back stage: load extension, write-data select,
// store-data forwarding toward MEM and a retired-instruction counter.
module pipeline_wb
  import pipeline_wb_pkg::*;
#(
  parameter int unsigned     CNT_W     = 32,
  parameter logic [XLEN-1:0] RESET_PC4 = 32'h0000_0004
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic           flush,
  pipeline_wb_if.slave   bus
);

  mem_wb_t          entry;
  mem_wb_t          cap_c;
  mem_wb_t          flush_c;
  logic [CNT_W-1:0] retired;
  logic [XLEN-1:0]  ld_data_c;
  logic [XLEN-1:0]  wb_data_c;
  logic             reg_wr_c;
  logic             retire_c;

  // Incoming slot, and the same slot with its control squashed for a flush.
  always_comb begin
    cap_c.valid   = bus.Mem_Valid;
    cap_c.reg_wr  = bus.Mem_RegWr;
    cap_c.mtr     = bus.Mem_MemtoReg;
    cap_c.ld_type = bus.Mem_LdType;
    cap_c.wr_addr = bus.Mem_WrAddr;
    cap_c.off     = bus.Mem_outA[OFF_W-1:0];
    cap_c.alu     = bus.Mem_outA;
    cap_c.rdata   = bus.Mem_outB;
    cap_c.pc4     = bus.Mem_PC4;

    flush_c         = cap_c;
    flush_c.valid   = 1'b0;
    flush_c.reg_wr  = 1'b0;
    flush_c.mtr     = MTR_W'(MTR_ALU);
    flush_c.ld_type = LDT_W'(LD_W);
  end

  assign retire_c = bus.Mem_Valid & ~flush & ~stall;

  // flush beats stall beats normal capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry     <= '0;
      entry.pc4 <= RESET_PC4;
      retired   <= '0;
    end else begin
      if (flush) begin
        entry <= flush_c;
      end else if (!stall) begin
        entry <= cap_c;
      end
      if (retire_c) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  pipeline_wb_load_extend u_load_extend (
    .data     (entry.rdata),
    .off      (entry.off),
    .ld_type  (entry.ld_type),
    .result_c (ld_data_c)
  );

  // MemtoReg 11 falls through to the ALU result.
  always_comb begin
    wb_data_c = entry.alu;
    case (entry.mtr)
      MTR_MEM: wb_data_c = ld_data_c;
      MTR_PC4: wb_data_c = entry.pc4;
      default: wb_data_c = entry.alu;
    endcase
  end

  assign reg_wr_c = entry.reg_wr & entry.valid & (entry.wr_addr != '0);

  assign bus.WB_dataB   = wb_data_c;
  assign bus.WB_WrAddr  = entry.wr_addr;
  assign bus.WB_RegWr   = reg_wr_c;
  assign bus.WB_retired = retired;
  // Combinational so it stays valid while the slot is held by a stall.
  assign bus.Forwardsw  = bus.Mem_MemWr & reg_wr_c & (entry.wr_addr == bus.Mem_Rt);

endmodule
